// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory target with programmable wait states
module dmem_responder #(
  parameter int AW = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  localparam logic [3:0] LP_WLOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  state_t r_state, w_next;
  logic [3:0] r_cnt, r_be;
  logic r_we, r_err;
  logic [AW-1:0] r_idx;
  logic [31:0] r_wdata, r_rdata;
  logic [31:0] r_mem [2**AW];
  logic w_err, w_take;
  assign w_err = (req_addr[1:0] != 2'd0) || ((req_addr >> (AW + 2)) != 32'd0);
  assign w_take = (r_state == S_IDLE) && req_valid;
  assign req_ready = r_state == S_IDLE;
  assign resp_valid = r_state == S_RESP;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_err ? S_RESP : (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // response fields change only when a new response is produced
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= 4'd0;
      r_we <= 1'b0;
      r_idx <= '0;
      r_be <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_we <= req_we;
        r_idx <= req_addr[AW+1:2];
        r_be <= req_be;
        r_wdata <= req_wdata;
        r_cnt <= LP_WLOAD;
        if (w_err) begin
          r_err <= 1'b1;
          r_rdata <= 32'd0;
        end
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      if (r_state == S_ACCESS) begin
        r_err <= 1'b0;
        r_rdata <= r_we ? 32'd0 : r_mem[r_idx];
      end
    end
  always_ff @(posedge clk)
    if (r_state == S_ACCESS && r_we)
      for (int b = 0; b < 4; b++)
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
endmodule
